// File: rtl/j_stream_fifo.sv
// j_stream_fifo -- parametrised synchronous FIFO on the j-stream.
// Decouples a j-stream producer from its consumer with a valid/ready
// handshake on both sides, first-word fall-through output, an occupancy
// count, an almost-full flag and a synchronous flush.
//
// Ports
//   clock       rising-edge clock
//   reset       asynchronous active-low reset
//   flush       synchronous clear of contents (active-high)
//   in_valid    producer has a word on in_j
//   in_j        producer payload [DATA_W]
//   in_ready    FIFO accepts a word this cycle
//   out_valid   out_j holds the oldest stored word
//   out_j       consumer payload [DATA_W]
//   out_ready   consumer accepts out_j this cycle
//   count       words stored [$clog2(DEPTH+1)]
//   almost_full count >= AF_LEVEL
module j_stream_fifo #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_j,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_j,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // and the occupancy is simply the modular difference.
  logic [AW:0]       wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              push, pop, full;

  // For a power-of-two DEPTH the pointer difference already has CW bits.
  assign count       = CW'(wr_ptr - rd_ptr);
  assign full        = (count == CW'(DEPTH));
  assign in_ready    = ~full | flush;
  assign out_valid   = (count != '0);
  assign out_j       = mem[rd_ptr[AW-1:0]];
  assign almost_full = (count >= CW'(AF_LEVEL));

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage has no reset; contents are only visible behind out_valid.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_j;
  end

endmodule
